// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ execute stage: instruction codes,
// ALU function codes, condition selectors and the condition-code bundle.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage

// File: rtl/execute_alu64.sv
// 64-bit Y86 ALU: computes b op a and the zero/sign/overflow flags of the result.
module alu64
    import y86_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  fn,
    output logic [63:0] r,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    // Operand order follows the ISA: subtraction is b - a, and undefined fn yields zero.
    always_comb begin
        r  = '0;
        of = 1'b0;
        case (fn)
            ALU_ADD: begin
                r  = b + a;
                of = (a[63] == b[63]) && (r[63] != b[63]);
            end
            ALU_SUB: begin
                r  = b - a;
                of = (a[63] != b[63]) && (r[63] != b[63]);
            end
            ALU_AND: r = b & a;
            ALU_XOR: r = b ^ a;
            default: r = '0;
        endcase
        zf = (r == 64'd0);
        sf = r[63];
    end

endmodule

// File: rtl/execute.sv
// SEQ Y86-64 execute stage: operand mux into the ALU, condition-code register
// loaded only by OPq, and jXX/cmovXX condition evaluation from the stored codes.
module execute
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic [63:0] valE,
    output logic        condition,
    output logic        ZF,
    output logic        SF,
    output logic        OF
);

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_fn;
    logic [63:0] alu_r;
    logic        alu_zf;
    logic        alu_sf;
    logic        alu_of;
    logic        use_alu;
    cc_t         cc;

    // Every address/move computation is routed through the one adder; moves add to zero.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fn  = ALU_ADD;
        use_alu = 1'b1;
        case (icode)
            I_CMOVXX: alu_a = valA;
            I_IRMOVQ: alu_a = valC;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = valC;
                alu_b = valB;
            end
            I_OPQ: begin
                alu_a  = valA;
                alu_b  = valB;
                alu_fn = ifun;
            end
            I_CALL, I_PUSHQ: begin
                alu_a  = 64'd8;
                alu_b  = valB;
                alu_fn = ALU_SUB;
            end
            I_RET, I_POPQ: begin
                alu_a = 64'd8;
                alu_b = valB;
            end
            default: use_alu = 1'b0;
        endcase
    end

    alu64 u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .fn (alu_fn),
        .r  (alu_r),
        .zf (alu_zf),
        .sf (alu_sf),
        .of (alu_of)
    );

    assign valE = use_alu ? alu_r : 64'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc <= '0;
        end else if (icode == I_OPQ && ifun <= ALU_XOR) begin
            cc <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
        end
    end

    assign ZF = cc.zf;
    assign SF = cc.sf;
    assign OF = cc.of;

    // Signed comparisons use SF^OF so they stay correct when the subtraction overflowed.
    always_comb begin
        condition = 1'b0;
        if (icode == I_CMOVXX || icode == I_JXX) begin
            case (ifun)
                C_ALWAYS: condition = 1'b1;
                C_LE:     condition = (cc.sf ^ cc.of) | cc.zf;
                C_L:      condition = cc.sf ^ cc.of;
                C_E:      condition = cc.zf;
                C_NE:     condition = ~cc.zf;
                C_GE:     condition = ~(cc.sf ^ cc.of);
                C_G:      condition = ~(cc.sf ^ cc.of) & ~cc.zf;
                default:  condition = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the SEQ execute stage.
module tb_execute;

    logic        clk;
    logic        reset;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        condition;
    logic        ZF;
    logic        SF;
    logic        OF;

    int checks;
    int failures;

    execute dut (
        .clk       (clk),
        .reset     (reset),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .valE      (valE),
        .condition (condition),
        .ZF        (ZF),
        .SF        (SF),
        .OF        (OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        icode = ic;
        ifun  = fn;
        valA  = a;
        valB  = b;
        valC  = c;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        checks++;
        if ({ZF, SF, OF} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_cc: got %b expected 000", {ZF, SF, OF});
        end
        checks++;
        if (valE !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_nop_valE: got %h expected 0", valE);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
        checks++;
        if (valE !== 64'd3) begin
            failures++;
            $display("[TB] FAIL add_valE: got %h expected 3", valE);
        end
        step();
        checks++;
        if ({ZF, SF, OF} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL add_cc: got %b expected 000", {ZF, SF, OF});
        end
        drive(4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        checks++;
        if (valE !== 64'd0) begin
            failures++;
            $display("[TB] FAIL wrap_valE: got %h expected 0", valE);
        end
        step();
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL wrap_cc: got %b expected 100", {ZF, SF, OF});
        end
    endtask

    task automatic test_sub();
        drive(4'h6, 4'h1, 64'd1, 64'd2, 64'd0);
        checks++;
        if (valE !== 64'd1) begin
            failures++;
            $display("[TB] FAIL sub_valE: got %h expected 1", valE);
        end
        step();
        checks++;
        if ({ZF, SF, OF} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL sub_cc: got %b expected 000", {ZF, SF, OF});
        end
        drive(4'h6, 4'h1, 64'd2, 64'd2, 64'd0);
        checks++;
        if (valE !== 64'd0) begin
            failures++;
            $display("[TB] FAIL sub_zero_valE: got %h expected 0", valE);
        end
        checks++;
        if (ZF !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cc_latency: got ZF=%b expected 0 before edge", ZF);
        end
        step();
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL sub_zero_cc: got %b expected 100", {ZF, SF, OF});
        end
    endtask

    task automatic test_logic_ops();
        drive(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0);
        checks++;
        if (valE !== 64'hF000) begin
            failures++;
            $display("[TB] FAIL and_valE: got %h expected f000", valE);
        end
        drive(4'h6, 4'h3, 64'hF0F0, 64'hFF00, 64'd0);
        checks++;
        if (valE !== 64'h0FF0) begin
            failures++;
            $display("[TB] FAIL xor_valE: got %h expected 0ff0", valE);
        end
        drive(4'h6, 4'h4, 64'hF0F0, 64'hFF00, 64'd0);
        checks++;
        if (valE !== 64'd0) begin
            failures++;
            $display("[TB] FAIL bad_op_valE: got %h expected 0", valE);
        end
        step();
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bad_op_holds_cc: got %b expected 100", {ZF, SF, OF});
        end
    endtask

    task automatic test_overflow_branch();
        drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        checks++;
        if (valE !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("[TB] FAIL ovf_valE: got %h expected 8000000000000000", valE);
        end
        step();
        checks++;
        if ({ZF, SF, OF} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL ovf_cc: got %b expected 011", {ZF, SF, OF});
        end
        drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cond_l: got %b expected 0", condition);
        end
        drive(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cond_le: got %b expected 0", condition);
        end
        drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cond_ge: got %b expected 1", condition);
        end
        drive(4'h2, 4'h6, 64'h1234, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b1 || valE !== 64'h1234) begin
            failures++;
            $display("[TB] FAIL cmov_g: got cond=%b valE=%h expected 1/1234", condition, valE);
        end
        drive(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cond_ne: got %b expected 1", condition);
        end
        drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cond_undef: got %b expected 0", condition);
        end
    endtask

    task automatic test_addressing();
        drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        checks++;
        if (valE !== 64'hF8) begin
            failures++;
            $display("[TB] FAIL pushq_valE: got %h expected f8", valE);
        end
        step();
        drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
        checks++;
        if (valE !== 64'h108) begin
            failures++;
            $display("[TB] FAIL popq_valE: got %h expected 108", valE);
        end
        step();
        drive(4'h4, 4'h0, 64'd0, 64'h10, 64'd8);
        checks++;
        if (valE !== 64'h18) begin
            failures++;
            $display("[TB] FAIL rmmovq_valE: got %h expected 18", valE);
        end
        step();
        drive(4'h8, 4'h0, 64'd0, 64'h200, 64'd0);
        checks++;
        if (valE !== 64'h1F8) begin
            failures++;
            $display("[TB] FAIL call_valE: got %h expected 1f8", valE);
        end
        step();
        drive(4'h9, 4'h0, 64'd0, 64'h200, 64'd0);
        checks++;
        if (valE !== 64'h208) begin
            failures++;
            $display("[TB] FAIL ret_valE: got %h expected 208", valE);
        end
        drive(4'h5, 4'h0, 64'd0, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8);
        checks++;
        if (valE !== 64'h38) begin
            failures++;
            $display("[TB] FAIL mrmovq_valE: got %h expected 38", valE);
        end
        drive(4'h3, 4'h0, 64'd5, 64'd6, 64'hABCD);
        checks++;
        if (valE !== 64'hABCD) begin
            failures++;
            $display("[TB] FAIL irmovq_valE: got %h expected abcd", valE);
        end
        drive(4'h7, 4'h0, 64'd5, 64'd6, 64'hABCD);
        checks++;
        if (valE !== 64'd0) begin
            failures++;
            $display("[TB] FAIL jxx_valE: got %h expected 0", valE);
        end
        drive(4'h0, 4'h0, 64'd5, 64'd6, 64'hABCD);
        checks++;
        if (valE !== 64'd0) begin
            failures++;
            $display("[TB] FAIL halt_valE: got %h expected 0", valE);
        end
        step();
        checks++;
        if ({ZF, SF, OF} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL non_opq_holds_cc: got %b expected 011", {ZF, SF, OF});
        end
    endtask

    task automatic test_async_reset();
        drive(4'h6, 4'h1, 64'd2, 64'd2, 64'd0);
        step();
        checks++;
        if (ZF !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_zf: got %b expected 1", ZF);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ZF, SF, OF} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL async_reset_cc: got %b expected 000", {ZF, SF, OF});
        end
        step();
        checks++;
        if (ZF !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_overrides_opq: got ZF=%b expected 0", ZF);
        end
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_cond_e: got %b expected 0", condition);
        end
        drive(4'h7, 4'h0, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_cond_always: got %b expected 1", condition);
        end
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irmovq_cond: got %b expected 0", condition);
        end
        drive(4'h3, 4'h4, 64'd0, 64'd0, 64'd0);
        checks++;
        if (condition !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irmovq_cond_ne: got %b expected 0", condition);
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        icode    = 4'h1;
        ifun     = 4'h0;
        valA     = '0;
        valB     = '0;
        valC     = '0;
        test_reset();
        test_add();
        test_sub();
        test_logic_ops();
        test_overflow_branch();
        test_addressing();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
